// File: rtl/eje4_pkg.sv
// Shared widths and FSM encoding for the eje4 hardware equivalence checker.
package eje4_pkg;

  localparam int N_IN  = 6;
  localparam int N_OUT = 3;
  localparam int N_VEC = 1 << N_IN;

  typedef logic [N_IN-1:0]  vec_t;
  typedef logic [N_OUT-1:0] res_t;
  typedef logic [N_IN:0]    cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_APPLY   = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam vec_t VEC_LAST = {N_IN{1'b1}};

endpackage

// File: rtl/eje4_err_acc.sv
// Mismatch accumulator: counts mismatching vectors and latches the first one seen.
module eje4_err_acc
  import eje4_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [N_OUT-1:0] mism,
  input  logic [N_IN-1:0]  vec,
  output logic [N_IN:0]    err_count,
  output logic [N_IN-1:0]  first_err_vec,
  output logic [N_OUT-1:0] first_err_mask
);

  cnt_t err_count_q, err_count_d;
  vec_t first_vec_q, first_vec_d;
  res_t first_mask_q, first_mask_d;

  always_comb begin
    err_count_d  = err_count_q;
    first_vec_d  = first_vec_q;
    first_mask_d = first_mask_q;
    if (clear) begin
      err_count_d  = '0;
      first_vec_d  = '0;
      first_mask_d = '0;
    end else if (en && (mism != '0)) begin
      err_count_d = err_count_q + {{N_IN{1'b0}}, 1'b1};
      // A zero count means nothing has been captured yet in this sweep.
      if (err_count_q == '0) begin
        first_vec_d  = vec;
        first_mask_d = mism;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q  <= '0;
      first_vec_q  <= '0;
      first_mask_q <= '0;
    end else begin
      err_count_q  <= err_count_d;
      first_vec_q  <= first_vec_d;
      first_mask_q <= first_mask_d;
    end
  end

  assign err_count      = err_count_q;
  assign first_err_vec  = first_vec_q;
  assign first_err_mask = first_mask_q;

endmodule

// File: rtl/eje4_checker.sv
// Sweeps every input vector of eje4, compares both implementations' outputs and
// reports the mismatch count and the first failing vector under a start/done handshake.
module eje4_checker
  import eje4_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [N_IN-1:0]  vec_out,
  input  logic [N_OUT-1:0] res_1,
  input  logic [N_OUT-1:0] res_2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_count,
  output logic [N_IN-1:0]  first_err_vec,
  output logic [N_OUT-1:0] first_err_mask,
  output logic [1:0]       dbg_state
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t          state_q, state_d;
  vec_t            vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            acc_clear;
  logic            acc_en;
  res_t            mism;

  assign mism = res_1 ^ res_2;

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_APPLY;
          vec_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          acc_clear = 1'b1;
        end else if (state_q == ST_DONE) begin
          // Results are published one cycle after DONE is entered, once the
          // terminal compare has landed in the accumulator.
          done_d = 1'b1;
          pass_d = (err_count == '0);
        end
      end
      ST_APPLY: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          state_d = ST_COMPARE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_COMPARE: begin
        acc_en = 1'b1;
        if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_APPLY;
          vec_d   = vec_q + {{(N_IN-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  eje4_err_acc u_acc (
    .clk            (clk),
    .reset          (reset),
    .clear          (acc_clear),
    .en             (acc_en),
    .mism           (mism),
    .vec            (vec_q),
    .err_count      (err_count),
    .first_err_vec  (first_err_vec),
    .first_err_mask (first_err_mask)
  );

  assign vec_out   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_eje4_checker.sv
// Bench for eje4_checker: stub eje4 with injectable per-vector faults, scoreboard
// of expected sweep results, and a SETTLE=3 instance driven by a delayed stub.
module tb_eje4_checker;
  import eje4_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT with default settle
  logic       start1 = 1'b0;
  logic [5:0] vec1;
  logic [2:0] r11, r12;
  logic       busy1, done1, pass1;
  logic [6:0] err1;
  logic [5:0] fv1;
  logic [2:0] fm1;
  logic [1:0] st1;

  // DUT with three settle cycles
  logic       start3 = 1'b0;
  logic [5:0] vec3;
  logic [2:0] r31, r32, d1, d2;
  logic       busy3, done3, pass3;
  logic [6:0] err3;
  logic [5:0] fv3;
  logic [2:0] fm3;
  logic [1:0] st3;

  logic [2:0] fmask [64];

  int n_checks = 0;
  int n_pass   = 0;

  logic [16:0] exp1_q[$];
  logic [16:0] exp3_q[$];

  // Stand-in for the eje4 logic function
  function automatic logic [2:0] f_ref(input logic [5:0] v);
    logic a, b, c, d, e, f;
    {a, b, c, d, e, f} = v;
    f_ref = {(a & b) | (c & ~d), b ^ e ^ f, ~(a | f) | d};
  endfunction

  assign r11 = f_ref(vec1);
  assign r12 = r11 ^ fmask[vec1];
  assign r31 = f_ref(vec3);
  always @(posedge clk) begin
    d1 <= r31;
    d2 <= d1;
  end
  assign r32 = d2 ^ fmask[vec3];

  eje4_checker u_dut1 (
    .clk(clk), .reset(rst), .start(start1), .vec_out(vec1), .res_1(r11), .res_2(r12),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_vec(fv1), .first_err_mask(fm1), .dbg_state(st1)
  );

  eje4_checker #(.SETTLE(3)) u_dut3 (
    .clk(clk), .reset(rst), .start(start3), .vec_out(vec3), .res_1(r31), .res_2(r32),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_err_vec(fv3), .first_err_mask(fm3), .dbg_state(st3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Expected sweep result {pass, err_count, first_vec, first_mask} from the fault table
  function automatic logic [16:0] model();
    int cnt = 0;
    logic [5:0] fv = '0;
    logic [2:0] fm = '0;
    for (int v = 0; v < 64; v++) begin
      if (fmask[v] != 3'd0) begin
        if (cnt == 0) begin
          fv = 6'(v);
          fm = fmask[v];
        end
        cnt++;
      end
    end
    model = {(cnt == 0), 7'(cnt), fv, fm};
  endfunction

  task automatic set_mask(input int mode, input int idx, input logic [2:0] bits);
    for (int v = 0; v < 64; v++) begin
      case (mode)
        0: fmask[v] = 3'd0;
        1: fmask[v] = (v == idx) ? bits : 3'd0;
        2: fmask[v] = 3'b111;
        default: fmask[v] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      endcase
    end
  endtask

  // Monitor: compare results against the scoreboard whenever done rises
  logic done1_prev = 1'b0;
  logic done3_prev = 1'b0;
  logic [16:0] e1, e3;

  always @(negedge clk) begin
    if (done1 && !done1_prev) begin
      if (exp1_q.size() == 0) check("unexpected_done1", 32'd1, 32'd0);
      else begin
        e1 = exp1_q.pop_front();
        check("pass1", pass1, e1[16]);
        check("err_count1", err1, e1[15:9]);
        check("first_vec1", fv1, e1[8:3]);
        check("first_mask1", fm1, e1[2:0]);
      end
    end
    if (done3 && !done3_prev) begin
      if (exp3_q.size() == 0) check("unexpected_done3", 32'd1, 32'd0);
      else begin
        e3 = exp3_q.pop_front();
        check("pass3", pass3, e3[16]);
        check("err_count3", err3, e3[15:9]);
        check("first_vec3", fv3, e3[8:3]);
        check("first_mask3", fm3, e3[2:0]);
      end
    end
    done1_prev <= done1;
    done3_prev <= done3;
  end

  function automatic logic pick(input int which, input logic a, input logic b);
    pick = (which == 1) ? a : b;
  endfunction

  task automatic sweep(input int which, input bit poke, input int exp_lat);
    int cyc;
    int bcnt;
    @(negedge clk);
    if (which == 1) begin start1 = 1'b1; exp1_q.push_back(model()); end
    else begin start3 = 1'b1; exp3_q.push_back(model()); end
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
    check("start_busy", pick(which, busy1, busy3), 1'b1);
    check("start_done_low", pick(which, done1, done3), 1'b0);
    check("start_err_clear", (which == 1) ? err1 : err3, 7'd0);
    cyc  = 0;
    bcnt = 1;
    while (!pick(which, done1, done3) && cyc < exp_lat + 50) begin
      @(posedge clk); #1;
      cyc++;
      if (pick(which, busy1, busy3)) bcnt++;
      if (poke && cyc == 10) begin
        if (which == 1) start1 = 1'b1;
        else start3 = 1'b1;
      end
      if (poke && cyc == 11) begin
        start1 = 1'b0;
        start3 = 1'b0;
      end
    end
    check("done_latency", cyc, exp_lat);
    check("busy_cycles", bcnt, exp_lat - 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vec"}, vec1, 6'd0);
    check({tag, "_busy"}, busy1, 1'b0);
    check({tag, "_done"}, done1, 1'b0);
    check({tag, "_pass"}, pass1, 1'b0);
    check({tag, "_err"}, err1, 7'd0);
    check({tag, "_fv"}, fv1, 6'd0);
    check({tag, "_fm"}, fm1, 3'd0);
    check({tag, "_state"}, st1, 2'(ST_IDLE));
  endtask

  task automatic reset_mid_sweep();
    int cyc = 0;
    int seen = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    while (vec1 != 6'h15 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reach_0x15", vec1, 6'h15);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (300) begin
      @(posedge clk); #1;
      if (done1) seen++;
    end
    check("no_done_after_rst", seen, 0);
    check("idle_after_rst", st1, 2'(ST_IDLE));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    set_mask(0, 0, 3'd0);
    #1;
    check_all_zero("rst0");
    check("rst0_state3", st3, 2'(ST_IDLE));
    check("rst0_done3", done3, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    set_mask(0, 0, 3'd0);        sweep(1, 1'b0, 129);
    set_mask(1, 6'h2A, 3'b010);  sweep(1, 1'b0, 129);
    set_mask(2, 0, 3'd0);        sweep(1, 1'b0, 129);
    set_mask(1, $urandom_range(0, 63), 3'(1 << $urandom_range(0, 2)));
    sweep(1, 1'b0, 129);
    set_mask(3, 0, 3'd0);        sweep(1, 1'b0, 129);
    set_mask(3, 0, 3'd0);        sweep(1, 1'b1, 129);
    set_mask(0, 0, 3'd0);        sweep(1, 1'b0, 129);

    reset_mid_sweep();

    set_mask(0, 0, 3'd0);        sweep(3, 1'b0, 257);
    set_mask(3, 0, 3'd0);        sweep(3, 1'b0, 257);

    repeat (5) @(posedge clk);
    check("exp1_drained", exp1_q.size(), 0);
    check("exp3_drained", exp3_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
